// File: rtl/alu_pipe_n.sv
// -----------------------------------------------------------------------------
// alu_pipe_n
//   Single-stage pipelined ALU. It computes eight logic and arithmetic
//   operations on WIDTH-bit operands and registers the result and the flags.
//   A stored chain carry and zero let wide operands be added or subtracted as
//   a sequence of word-serial transactions (use_c=1 on every word but the
//   first).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand transaction present
//   in_ready   block can accept a transaction this cycle (combinational)
//   a, b       WIDTH-bit operands
//   op         operation select:
//                000 ~a, 001 ~b, 010 a&b, 011 a|b,
//                100 a^b, 101 ~(a^b), 110 ADD, 111 SUB
//   use_c      chain mode: take carry-in and zero from the previous ADD/SUB
//   out_valid  result registers hold an unconsumed result
//   out_ready  consumer takes the result this cycle
//   y          registered result
//   c,n,z,v    registered carry, negative, zero and signed-overflow flags
//   carry_q    stored chain carry
// -----------------------------------------------------------------------------
module alu_pipe_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             use_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             c,
   output logic             n,
   output logic             z,
   output logic             v,
   output logic             carry_q
);

   localparam logic [2:0] OP_NOTA = 3'b000;
   localparam logic [2:0] OP_NOTB = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b111;

   // Result / flag registers
   logic [WIDTH-1:0] r_y;
   logic             r_c;
   logic             r_n;
   logic             r_z;
   logic             r_v;
   logic             r_out_valid;

   // Chain state: carry and zero from the most recently accepted ADD/SUB
   logic             r_carry;
   logic             r_zero;

   // Combinational datapath
   logic             w_in_ready;
   logic             w_accept;
   logic             w_is_arith;
   logic             w_is_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_carry_into_msb;
   logic [WIDTH-1:0] w_res;
   logic             w_res_is_zero;
   logic             w_c;
   logic             w_v;
   logic             w_z;

   // A new transaction can be taken when the output slot is empty or is
   // being drained on this same edge; never while reset is asserted.
   assign w_in_ready = ~reset & (~r_out_valid | out_ready);
   assign w_accept   = in_valid & w_in_ready;

   // Operation decode, shared adder and flag generation
   always_comb begin
      w_is_arith       = 1'b0;
      w_is_sub         = 1'b0;
      w_b_eff          = b;
      w_cin            = 1'b0;
      w_sum            = {(WIDTH + 1){1'b0}};
      w_carry_into_msb = 1'b0;
      w_res            = {WIDTH{1'b0}};
      w_res_is_zero    = 1'b0;
      w_c              = 1'b0;
      w_v              = 1'b0;
      w_z              = 1'b0;

      w_is_arith = (op == OP_ADD) | (op == OP_SUB);
      w_is_sub   = (op == OP_SUB);

      // SUB is a + ~b + cin; the unchained SUB carry-in is 1 (no borrow).
      if (w_is_sub) begin
         w_b_eff = ~b;
      end else begin
         w_b_eff = b;
      end

      if (use_c) begin
         w_cin = r_carry;
      end else begin
         w_cin = w_is_sub;
      end

      w_sum = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

      // Sum bit = a ^ b ^ carry_in, so the carry into the MSB is recovered
      // from the MSB operands and the MSB of the sum.
      w_carry_into_msb = w_sum[WIDTH-1] ^ a[WIDTH-1] ^ w_b_eff[WIDTH-1];

      case (op)
         OP_NOTA: w_res = ~a;
         OP_NOTB: w_res = ~b;
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_XNOR: w_res = ~(a ^ b);
         OP_ADD:  w_res = w_sum[WIDTH-1:0];
         OP_SUB:  w_res = w_sum[WIDTH-1:0];
         default: w_res = {WIDTH{1'b0}};
      endcase

      w_res_is_zero = (w_res == {WIDTH{1'b0}});

      if (w_is_arith) begin
         w_c = w_sum[WIDTH];
         w_v = w_carry_into_msb ^ w_sum[WIDTH];
         // A chained word is only zero if every earlier word was zero too.
         if (use_c) begin
            w_z = w_res_is_zero & r_zero;
         end else begin
            w_z = w_res_is_zero;
         end
      end else begin
         w_c = 1'b0;
         w_v = 1'b0;
         w_z = w_res_is_zero;
      end
   end

   // Output register stage and chain state update
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y         <= {WIDTH{1'b0}};
         r_c         <= 1'b0;
         r_n         <= 1'b0;
         r_z         <= 1'b0;
         r_v         <= 1'b0;
         r_out_valid <= 1'b0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b1;
      end else begin
         if (w_accept) begin
            r_y         <= w_res;
            r_c         <= w_c;
            r_n         <= w_res[WIDTH-1];
            r_z         <= w_z;
            r_v         <= w_v;
            r_out_valid <= 1'b1;
            // Logic ops leave the chain state untouched.
            if (w_is_arith) begin
               r_carry <= w_c;
               r_zero  <= w_z;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign c         = r_c;
   assign n         = r_n;
   assign z         = r_z;
   assign v         = r_v;
   assign carry_q   = r_carry;

endmodule

// File: tb/tb_alu_pipe_n.sv
module tb_alu_pipe_n;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         use_c;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         c, n, z, v;
   logic         carry_q;

   always #5 clk = ~clk;

   alu_pipe_n #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .use_c(use_c), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .c(c), .n(n), .z(z), .v(v),
      .carry_q(carry_q)
   );

   int checks = 0;
   int errors = 0;

   // Expected {y, c, n, z, v} in acceptance order
   logic [11:0] sb_q[$];
   bit          run = 1'b0;
   bit          m_pending = 1'b0;
   bit          m_carry = 1'b0;
   bit          m_zero  = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model with integer arithmetic; updates chain state on ADD/SUB.
   function automatic logic [11:0] ref_op(input int ia, input int ib, input int iop, input bit uc);
      int   yi, s, sr, sa, sb, cin;
      bit   cb, vb, zb, nb;
      logic [7:0] yb;
      cb = 1'b0; vb = 1'b0; s = 0; sr = 0; cin = 0; yi = 0;
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      case (iop)
         0: yi = 255 - ia;
         1: yi = 255 - ib;
         2: yi = ia & ib;
         3: yi = ia | ib;
         4: yi = ia ^ ib;
         5: yi = 255 - (ia ^ ib);
         6: begin
            cin = uc ? int'(m_carry) : 0;
            s   = ia + ib + cin;
            sr  = sa + sb + cin;
         end
         default: begin
            cin = uc ? int'(m_carry) : 1;
            s   = ia + (255 - ib) + cin;
            sr  = sa - sb - 1 + cin;
         end
      endcase
      if (iop >= 6) begin
         yi = s % 256;
         cb = (s >= 256);
         vb = (sr > 127) || (sr < -128);
         zb = (yi == 0) && (uc ? m_zero : 1'b1);
         m_carry = cb;
         m_zero  = zb;
      end else begin
         zb = (yi == 0);
      end
      nb = (yi >= 128);
      yb = yi[7:0];
      return {yb, cb, nb, zb, vb};
   endfunction

   // Model: predicts handshake, queues expected results, tracks chain state
   initial begin
      bit exp_rdy;
      forever begin
         @(negedge clk);
         if (run) begin
            exp_rdy = !reset && (!m_pending || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, m_pending);
            chk("carry_q", carry_q, m_carry);
            if (reset) begin
               sb_q.delete();
               m_pending = 1'b0;
               m_carry   = 1'b0;
               m_zero    = 1'b1;
            end else if (in_valid && exp_rdy) begin
               sb_q.push_back(ref_op(int'(a), int'(b), int'(op), use_c));
               m_pending = 1'b1;
            end else if (out_ready) begin
               m_pending = 1'b0;
            end
         end
      end
   end

   // Monitor: compares consumed results in order, checks stall stability
   initial begin
      bit          prev_stall = 1'b0;
      bit          prev_reset = 1'b0;
      logic [12:0] held = 13'd0;
      logic [11:0] exp;
      forever begin
         @(negedge clk);
         if (run) begin
            if (prev_stall && !prev_reset)
               chk("stall_hold", {out_valid, y, c, n, z, v}, held);
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_result", 32'd1, 32'd0);
               end else begin
                  exp = sb_q.pop_front();
                  chk("result", {y, c, n, z, v}, exp);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_reset = reset;
            held       = {out_valid, y, c, n, z, v};
         end
      end
   end

   task automatic drive(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [2:0] iop, input bit uc, input bit ordy, input bit rst);
      @(posedge clk);
      #1;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      op        = iop;
      use_c     = uc;
      out_ready = ordy;
      reset     = rst;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
      op = 3'b000; use_c = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 run = 1'b1;
      @(negedge clk);
      chk("reset_y", y, 8'h00);
      chk("reset_flags", {c, n, z, v}, 4'b0000);

      // First ADD: 0x7F + 0x01
      drive(1'b1, 8'h7F, 8'h01, 3'b110, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("add7f_valid", out_valid, 1'b1);
      chk("add7f_res", {y, c, n, z, v}, {8'h80, 4'b0101});

      // SUBs, then back-to-back chained ADD/SUB
      drive(1'b1, 8'h10, 8'h20, 3'b111, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'h20, 8'h20, 3'b111, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'hFF, 8'h01, 3'b110, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'h00, 8'h00, 3'b110, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("chain_add_res", {y, c, z}, {8'h01, 2'b00});
      drive(1'b1, 8'h34, 8'h34, 3'b111, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'h12, 8'h12, 3'b111, 1'b1, 1'b1, 1'b0);

      // Logic ops; use_c set to show it is ignored, carry_q must stay 1
      for (int i = 0; i < 6; i++)
         drive(1'b1, 8'hC3, 8'h5A, 3'(i), 1'b1, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("xnor_res", {y, c, v}, {8'h66, 2'b00});
      chk("logic_keeps_carry", carry_q, 1'b1);

      // Backpressure: three cycles of in_valid with out_ready low
      for (int i = 0; i < 3; i++)
         drive(1'b1, 8'h11, 8'h22, 3'b110, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'b1, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);

      // Reset while a result with carry_q=1 is pending
      drive(1'b1, 8'hFF, 8'h01, 3'b110, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 8'h00, 3'b110, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("rst_cycle_ready", in_ready, 1'b0);
      chk("rst_cycle_carry", carry_q, 1'b1);
      drive(1'b1, 8'h00, 8'h00, 3'b110, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_y", y, 8'h00);
      chk("post_rst_carry", carry_q, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("post_rst_chain", {out_valid, y, z}, {1'b1, 8'h00, 1'b1});

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
               3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);

      for (int i = 0; i < 5; i++)
         drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("queue_drained", sb_q.size(), 32'd0);
      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
